// File: rtl/servant_sleep_pkg.sv
// ---------------------------------------------------------------------------
// servant_sleep_pkg
//   Shared types and helpers for the servant sleep/wake controller.
//   - sleep_state_e    : controller state (RUN, DRAIN, SLEEP, WAKE)
//   - delay_cnt_width(): width of the drain/wake delay counter, which must
//                        hold max(SLEEP_DELAY, WAKE_DELAY); never below 1 bit.
// ---------------------------------------------------------------------------
package servant_sleep_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_SLEEP = 2'd2,
      ST_WAKE  = 2'd3
   } sleep_state_e;

   function automatic int delay_cnt_width(input int sleep_delay, input int wake_delay);
      int max_dly;
      int w;
      max_dly = (sleep_delay > wake_delay) ? sleep_delay : wake_delay;
      w       = $clog2(max_dly + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage : servant_sleep_pkg

// File: rtl/servant_clk_gate.sv
// ---------------------------------------------------------------------------
// servant_clk_gate
//   Glitch-free clock gate: the enable is captured on the falling edge of
//   i_clk, so it can only change while i_clk is low and the AND gate never
//   produces a runt pulse. Keep all clock gating in this module so it can be
//   replaced by a technology ICG cell.
// Ports
//   i_clk    in   free-running source clock
//   i_rst_n  in   asynchronous active-low reset (forces the gate open)
//   i_en     in   clock enable, i_clk posedge domain
//   o_gclk   out  gated clock = i_clk & enable-captured-on-negedge
// ---------------------------------------------------------------------------
module servant_clk_gate (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   output logic o_gclk
);

   logic en_neg_q;

   // Reset opens the gate so the core clock runs while the block is in reset.
   always_ff @(negedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         en_neg_q <= 1'b1;
      end else begin
         en_neg_q <= i_en;
      end
   end

   assign o_gclk = i_clk & en_neg_q;

endmodule : servant_clk_gate

// File: rtl/servant_sleep_ctrl.sv
// ---------------------------------------------------------------------------
// servant_sleep_ctrl
//   Sleep/wake controller for the servant core. Gates the core clock when the
//   core requests sleep and restores it on a wakeup request or an unmasked
//   interrupt. Interrupts are synchronised, turned into per-channel pending
//   bits (edge channels sticky until cleared, level channels transparent),
//   and the number of completed sleeps is counted (saturating).
// Ports
//   i_clk         in   free-running clock, also the source of o_gclk
//   i_rst_n       in   asynchronous active-low reset
//   i_sleep_req   in   sleep request (level; rising edge starts a sleep)
//   i_wakeup_req  in   wakeup request (level)
//   i_irq         in   [NUM_IRQ] raw interrupts, may be asynchronous
//   i_irq_mask    in   [NUM_IRQ] 1 = channel may wake the core / raise o_irq
//   i_pend_clr    in   [NUM_IRQ] pending clear pulse (edge channels only)
//   o_pending     out  [NUM_IRQ] pending bits, unmasked
//   o_irq         out  registered OR of masked pending bits
//   o_clk_en      out  registered core clock enable
//   o_gclk        out  glitch-free gated clock for the core
//   o_sleeping    out  1 while in SLEEP or WAKE
//   o_sleep_cnt   out  [CNT_W] completed sleeps, saturating
// ---------------------------------------------------------------------------
module servant_sleep_ctrl
   import servant_sleep_pkg::*;
#(
   parameter int                 NUM_IRQ     = 1,
   parameter logic [NUM_IRQ-1:0] IRQ_EDGE    = '1,
   parameter int                 SYNC_STAGES = 2,
   parameter int                 SLEEP_DELAY = 2,
   parameter int                 WAKE_DELAY  = 1,
   parameter int                 CNT_W       = 16
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_sleep_req,
   input  logic               i_wakeup_req,
   input  logic [NUM_IRQ-1:0] i_irq,
   input  logic [NUM_IRQ-1:0] i_irq_mask,
   input  logic [NUM_IRQ-1:0] i_pend_clr,
   output logic [NUM_IRQ-1:0] o_pending,
   output logic               o_irq,
   output logic               o_clk_en,
   output logic               o_gclk,
   output logic               o_sleeping,
   output logic [CNT_W-1:0]   o_sleep_cnt
);

   localparam int DLY_W = delay_cnt_width(SLEEP_DELAY, WAKE_DELAY);
   // Counter preload values; a delay of 0 bypasses the state entirely.
   localparam logic [DLY_W-1:0] SLEEP_LOAD = DLY_W'((SLEEP_DELAY > 0) ? SLEEP_DELAY - 1 : 0);
   localparam logic [DLY_W-1:0] WAKE_LOAD  = DLY_W'((WAKE_DELAY > 0) ? WAKE_DELAY - 1 : 0);

   // ------------------------------------------------------------------
   // Interrupt synchroniser
   // ------------------------------------------------------------------
   logic [NUM_IRQ-1:0] irq_sync;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign irq_sync = i_irq;
      end else begin : g_sync
         logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];

         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               for (int s = 0; s < SYNC_STAGES; s++) begin
                  sync_q[s] <= '0;
               end
            end else begin
               sync_q[0] <= i_irq;
               for (int s = 1; s < SYNC_STAGES; s++) begin
                  sync_q[s] <= sync_q[s-1];
               end
            end
         end

         assign irq_sync = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Pending bits
   // ------------------------------------------------------------------
   logic [NUM_IRQ-1:0] irq_prev_q;
   logic [NUM_IRQ-1:0] pend_q;
   logic [NUM_IRQ-1:0] pend_d;
   logic [NUM_IRQ-1:0] irq_rise;
   logic               irq_q;

   assign irq_rise = irq_sync & ~irq_prev_q;

   // Edge channels: set term OR'd after the clear so a same-cycle set wins.
   // Level channels: pending simply mirrors the synchronised input.
   assign pend_d = ( IRQ_EDGE & (irq_rise | (pend_q & ~i_pend_clr)))
                 | (~IRQ_EDGE & irq_sync);

   // ------------------------------------------------------------------
   // Sleep/wake FSM
   // ------------------------------------------------------------------
   sleep_state_e     state_q;
   sleep_state_e     state_d;
   logic [DLY_W-1:0] cnt_q;
   logic [DLY_W-1:0] cnt_d;
   logic             sleep_req_q;
   logic             sleep_edge;
   logic             wake_evt;
   logic             clk_en_q;
   logic             sleep_done;
   logic [CNT_W-1:0] sleep_cnt_q;

   assign sleep_edge = i_sleep_req & ~sleep_req_q;
   // Uses next-cycle pending so an interrupt wakes the core in the same
   // cycle its pending bit is set.
   assign wake_evt   = i_wakeup_req | (|(pend_d & i_irq_mask));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_RUN: begin
            // A sleep request coinciding with a wake event is dropped.
            if (sleep_edge && !wake_evt) begin
               if (SLEEP_DELAY == 0) begin
                  state_d = ST_SLEEP;
               end else begin
                  state_d = ST_DRAIN;
                  cnt_d   = SLEEP_LOAD;
               end
            end
         end
         ST_DRAIN: begin
            if (wake_evt) begin
               state_d = ST_RUN;
            end else if (cnt_q == '0) begin
               state_d = ST_SLEEP;
            end else begin
               cnt_d = cnt_q - DLY_W'(1);
            end
         end
         ST_SLEEP: begin
            if (wake_evt) begin
               if (WAKE_DELAY == 0) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_WAKE;
                  cnt_d   = WAKE_LOAD;
               end
            end
         end
         ST_WAKE: begin
            // Wake events are ignored here; the settle delay always completes.
            if (cnt_q == '0) begin
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q - DLY_W'(1);
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // Only a real sleep (SLEEP/WAKE back to RUN) counts; aborted drains do not.
   assign sleep_done = ((state_q == ST_SLEEP) || (state_q == ST_WAKE)) && (state_d == ST_RUN);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_RUN;
         cnt_q       <= '0;
         clk_en_q    <= 1'b1;
         sleep_req_q <= 1'b0;
         irq_prev_q  <= '0;
         pend_q      <= '0;
         irq_q       <= 1'b0;
         sleep_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         clk_en_q    <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
         sleep_req_q <= i_sleep_req;
         irq_prev_q  <= irq_sync;
         pend_q      <= pend_d;
         irq_q       <= |(pend_d & i_irq_mask);
         if (sleep_done && (sleep_cnt_q != '1)) begin
            sleep_cnt_q <= sleep_cnt_q + CNT_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Clock gate and outputs
   // ------------------------------------------------------------------
   servant_clk_gate u_clk_gate (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (clk_en_q),
      .o_gclk  (o_gclk)
   );

   assign o_pending   = pend_q;
   assign o_irq       = irq_q;
   assign o_clk_en    = clk_en_q;
   assign o_sleeping  = (state_q == ST_SLEEP) || (state_q == ST_WAKE);
   assign o_sleep_cnt = sleep_cnt_q;

endmodule : servant_sleep_ctrl
